// File: rtl/pps_muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on magnitudes, with sign fix-up and pipeline stall/flush handling.
module pps_muldiv_ctrl #(
    parameter int MD_OP_SIZE = 3,
    parameter int MD_ITER    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  md_start_in,
    input  logic [MD_OP_SIZE-1:0] md_op_in,
    input  logic [31:0]           md_rs_in,
    input  logic [31:0]           md_rt_in,
    input  logic                  md_rd_req_in,
    input  logic                  md_rd_sel_in,
    input  logic                  md_flush_in,
    output logic                  md_busy_out,
    output logic                  md_stall_out,
    output logic                  md_done_out,
    output logic [31:0]           md_rdata_out,
    output logic [31:0]           md_hi_out,
    output logic [31:0]           md_lo_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

    localparam logic [MD_OP_SIZE-1:0] OP_MULT  = MD_OP_SIZE'(0);
    localparam logic [MD_OP_SIZE-1:0] OP_MULTU = MD_OP_SIZE'(1);
    localparam logic [MD_OP_SIZE-1:0] OP_DIV   = MD_OP_SIZE'(2);
    localparam logic [MD_OP_SIZE-1:0] OP_DIVU  = MD_OP_SIZE'(3);
    localparam logic [MD_OP_SIZE-1:0] OP_MTHI  = MD_OP_SIZE'(4);
    localparam logic [MD_OP_SIZE-1:0] OP_MTLO  = MD_OP_SIZE'(5);
    localparam logic [5:0]            CNT_LAST = 6'(MD_ITER - 1);

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] b_q;
    logic        is_div_q;
    logic        neg_res_q;
    logic        neg_rem_q;
    logic        div_zero_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        op_is_md;
    logic        op_is_mt;
    logic        op_signed;
    logic        op_div;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;

    always_comb begin
        op_is_md  = (md_op_in == OP_MULT) || (md_op_in == OP_MULTU) ||
                    (md_op_in == OP_DIV)  || (md_op_in == OP_DIVU);
        op_is_mt  = (md_op_in == OP_MTHI) || (md_op_in == OP_MTLO);
        op_signed = (md_op_in == OP_MULT) || (md_op_in == OP_DIV);
        op_div    = (md_op_in == OP_DIV)  || (md_op_in == OP_DIVU);
        rs_neg    = op_signed & md_rs_in[31];
        rt_neg    = op_signed & md_rt_in[31];
        rs_mag    = rs_neg ? -md_rs_in : md_rs_in;
        rt_mag    = rt_neg ? -md_rt_in : md_rt_in;
    end

    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [31:0] rem_sub;
    logic [63:0] acc_d;
    logic [63:0] prod_fix;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi_d;
    logic [31:0] res_lo_d;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        rem_sh  = {acc_q[63:32], acc_q[31]};
        rem_sub = rem_sh[31:0] - b_q;
        if (is_div_q) begin
            if (rem_sh >= {1'b0, b_q}) begin
                acc_d = {rem_sub, acc_q[30:0], 1'b1};
            end else begin
                acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
            end
        end else begin
            acc_d = {mul_sum, acc_q[31:1]};
        end

        prod_fix = neg_res_q ? -acc_d : acc_d;
        quo_mag  = acc_d[31:0];
        rem_mag  = acc_d[63:32];
        quo_fix  = div_zero_q ? 32'hFFFF_FFFF : (neg_res_q ? -quo_mag : quo_mag);
        rem_fix  = neg_rem_q ? -rem_mag : rem_mag;
        res_hi_d = is_div_q ? rem_fix : prod_fix[63:32];
        res_lo_d = is_div_q ? quo_fix : prod_fix[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers (acc/b/flags) are not reset; each start reloads them before use.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (md_start_in && !md_flush_in) begin
                        if (op_is_md) begin
                            acc_q      <= {32'd0, op_div ? rs_mag : rt_mag};
                            b_q        <= op_div ? rt_mag : rs_mag;
                            is_div_q   <= op_div;
                            neg_res_q  <= rs_neg ^ rt_neg;
                            neg_rem_q  <= rs_neg;
                            div_zero_q <= op_div && (md_rt_in == 32'd0);
                            cnt_q      <= '0;
                            state_q    <= ST_RUN;
                        end else if (md_op_in == OP_MTHI) begin
                            hi_q <= md_rs_in;
                        end else if (md_op_in == OP_MTLO) begin
                            lo_q <= md_rs_in;
                        end
                    end
                end
                ST_RUN: begin
                    if (md_flush_in) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 6'd1;
                        // Last step commits the sign-corrected result so FIN shows it with done.
                        if (cnt_q == CNT_LAST) begin
                            hi_q    <= res_hi_d;
                            lo_q    <= res_lo_d;
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Reserved op codes never stall, even while busy.
    assign md_busy_out  = (state_q != ST_IDLE);
    assign md_stall_out = md_busy_out &
                          ((md_start_in & (op_is_md | op_is_mt)) | md_rd_req_in);
    assign md_done_out  = done_q;
    assign md_rdata_out = md_rd_sel_in ? hi_q : lo_q;
    assign md_hi_out    = hi_q;
    assign md_lo_out    = lo_q;

endmodule

// File: tb/tb_pps_muldiv_ctrl.sv
// Self-checking bench for pps_muldiv_ctrl: vector table, directed corner sequences
// and random operations compared against an arithmetic reference model.
module tb_pps_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        rd_req;
    logic        rd_sel;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    pps_muldiv_ctrl #(.MD_OP_SIZE(3), .MD_ITER(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .md_start_in  (start),
        .md_op_in     (op),
        .md_rs_in     (rs),
        .md_rt_in     (rt),
        .md_rd_req_in (rd_req),
        .md_rd_sel_in (rd_sel),
        .md_flush_in  (flush),
        .md_busy_out  (busy),
        .md_stall_out (stall),
        .md_done_out  (done),
        .md_rdata_out (rdata),
        .md_hi_out    (hi),
        .md_lo_out    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a start for one edge; returns in cycle 1 of the operation.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        tick();
        start = 1'b0;
    endtask

    // Waits for done starting from cycle 1; lat is the cycle number done was seen in.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            3'd0: p = 64'(sa * sb);
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    initial begin
        int          lat;
        int          stall_cnt;
        int          done_seen;
        logic        done_at33;
        logic [2:0]  r_op;
        logic [31:0] r_rs;
        logic [31:0] r_rt;
        logic [63:0] exp;

        vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd2, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
        vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[6] = '{3'd3, 32'h8765_4321, 32'd0,         32'h8765_4321, 32'hFFFF_FFFF};
        vecs[7] = '{3'd2, 32'h8000_0001, 32'd0,         32'h8000_0001, 32'hFFFF_FFFF};
        vecs[8] = '{3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        vecs[9] = '{3'd1, 32'd3,         32'd5,         32'd0,         32'd15};

        start  = 1'b1;
        op     = 3'd0;
        rs     = 32'd9;
        rt     = 32'd9;
        rd_req = 1'b0;
        rd_sel = 1'b0;
        flush  = 1'b0;
        rst    = 1'b1;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_stall", stall, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_rdata", rdata, 0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
            check($sformatf("vec%0d_busy", i), busy, 1);
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
            tick();
            check($sformatf("vec%0d_done_width", i), done, 0);
            check($sformatf("vec%0d_idle", i), busy, 0);
        end

        // MTLO in IDLE, then flush of a DIVU in cycle 10.
        start = 1'b1;
        op    = 3'd5;
        rs    = 32'hA5A5_A5A5;
        #1;
        check("mtlo_no_stall", stall, 0);
        tick();
        start = 1'b0;
        check("mtlo_lo", lo, 32'hA5A5_A5A5);
        check("mtlo_busy", busy, 0);
        check("mtlo_done", done, 0);
        issue(3'd4, 32'h0BAD_F00D, 32'd0);
        check("mthi_hi", hi, 32'h0BAD_F00D);
        check("mthi_busy", busy, 0);
        issue(3'd3, 32'd1000, 32'd3);
        for (int c = 1; c < 10; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_lo_kept", lo, 32'hA5A5_A5A5);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        check("flush_no_done", 64'(done_seen), 0);
        check("flush_hi_kept", hi, 32'h0BAD_F00D);

        // MFHI from cycle 5 of MULTU 0xFFFFFFFF*0xFFFFFFFF stalls through cycle 33.
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int c = 1; c < 5; c++) tick();
        rd_req    = 1'b1;
        rd_sel    = 1'b1;
        stall_cnt = 0;
        done_at33 = 1'b0;
        for (int c = 5; c <= 33; c++) begin
            #1;
            if (stall === 1'b1) stall_cnt++;
            if (c == 33) done_at33 = done;
            tick();
        end
        #1;
        check("mfhi_stall_cycles", 64'(stall_cnt), 64'd29);
        check("mfhi_done_c33", done_at33, 1);
        check("mfhi_stall_released", stall, 0);
        check("mfhi_rdata", rdata, 32'hFFFF_FFFE);
        rd_req = 1'b0;
        tick();

        // Start and read together in IDLE: start accepted, read sees old LO.
        start  = 1'b1;
        op     = 3'd0;
        rs     = 32'd6;
        rt     = 32'hFFFF_FFF9;
        rd_req = 1'b1;
        rd_sel = 1'b0;
        #1;
        check("start_read_stall", stall, 0);
        check("start_read_rdata", rdata, 32'h0000_0001);
        tick();
        start  = 1'b0;
        rd_req = 1'b0;
        check("start_read_accepted", busy, 1);
        wait_done(lat);
        check("start_read_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        tick();

        // Reserved codes and flush-in-IDLE leave everything untouched.
        for (int k = 6; k < 8; k++) begin
            start = 1'b1;
            op    = 3'(k);
            rs    = 32'h5555_5555;
            #1;
            check($sformatf("reserved%0d_stall", k), stall, 0);
            tick();
            start = 1'b0;
            check($sformatf("reserved%0d_busy", k), busy, 0);
            check($sformatf("reserved%0d_hilo", k), {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        end
        start = 1'b1;
        op    = 3'd0;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("idle_flush_suppress", busy, 0);

        // Start presented in FIN is stalled and accepted in cycle 34.
        issue(3'd1, 32'd2, 32'd3);
        wait_done(lat);
        check("b2b_first_lo", lo, 32'd6);
        start = 1'b1;
        op    = 3'd1;
        rs    = 32'd4;
        rt    = 32'd5;
        #1;
        check("b2b_fin_stall", stall, 1);
        tick();
        check("b2b_c34_idle", busy, 0);
        tick();
        start = 1'b0;
        check("b2b_accepted", busy, 1);
        wait_done(lat);
        check("b2b_latency", 64'(lat), 64'd33);
        check("b2b_result", {hi, lo}, 64'd20);
        tick();

        // Reset in cycle 20 of a MULT, then MULTU 3*5.
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        for (int c = 1; c < 20; c++) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_hilo", {hi, lo}, 0);
        check("midrst_rdata", rdata, 0);
        rst = 1'b0;
        issue(3'd1, 32'd3, 32'd5);
        wait_done(lat);
        check("postrst_latency", 64'(lat), 64'd33);
        check("postrst_result", {hi, lo}, 64'd15);
        tick();

        // Random operations against the arithmetic model.
        for (int n = 0; n < 24; n++) begin
            r_op = 3'($urandom_range(0, 3));
            r_rs = $urandom;
            case ($urandom_range(0, 5))
                0:       r_rt = 32'd0;
                1:       r_rt = 32'($urandom_range(1, 15));
                2:       r_rt = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: r_rt = $urandom;
            endcase
            exp = ref_result(r_op, r_rs, r_rt);
            issue(r_op, r_rs, r_rt);
            wait_done(lat);
            check($sformatf("rand%0d_op%0d_%h_%h", n, r_op, r_rs, r_rt), {hi, lo}, exp);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
